// File: rtl/vec_mem_responder.sv
// Banked vector data memory: accepts one vector load/store at a time, moves BEATS
// rows of BANKS words, then answers with load beats or a single store ack.
module vec_mem_responder #(
   parameter int BANKS  = 8,
   parameter int DEPTH  = 120,
   parameter int VLEN   = 32,
   parameter int DW     = 32,
   parameter int ADDR_W = 7,
   parameter int LAT    = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic                w_valid,
   output logic                w_ready,
   input  logic [BANKS*DW-1:0] w_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [BANKS*DW-1:0] resp_data,
   output logic                resp_last,
   output logic                resp_err,
   output logic [2:0]          dbg_state
);
   localparam int BEATS  = VLEN / BANKS;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int CHK_W  = ADDR_W + 2;
   localparam logic [1:0] LAT_V = 2'(LAT);

   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WAIT, S_RDATA, S_ACK} state_t;

   state_t              state_q, state_d;
   logic                live_q;
   logic                we_q;
   logic                err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [BEAT_W-1:0]   beat_q;
   logic [1:0]          cnt_q;
   logic [BANKS*DW-1:0] mem [DEPTH];

   logic                req_fire, w_fire, wait_done, last_wbeat, req_err;
   logic [CHK_W-1:0]    last_row;
   logic [ADDR_W-1:0]   wr_row, rd_next;

   // All three channels use valid/ready: a transfer happens on a rising edge where
   // both are high; the producer holds valid and payload steady until that edge.
   assign req_ready  = (state_q == S_IDLE) && live_q;
   assign w_ready    = (state_q == S_WDATA);
   assign resp_valid = (state_q == S_RDATA) || (state_q == S_ACK);
   assign dbg_state  = state_q;

   assign req_fire   = req_valid && req_ready;
   assign w_fire     = w_valid && w_ready;
   assign wait_done  = (cnt_q == 2'd1);
   assign last_wbeat = (beat_q == BEAT_W'(BEATS - 1));

   // Range check is two bits wider than the address so the sum never wraps.
   assign last_row = CHK_W'(req_addr) + CHK_W'(BEATS - 1);
   assign req_err  = last_row > CHK_W'(DEPTH - 1);

   assign wr_row  = addr_q + ADDR_W'(beat_q);
   assign rd_next = addr_q + ADDR_W'(beat_q) + ADDR_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_fire) state_d = req_we ? S_WDATA : S_WAIT;
         S_WDATA: if (w_fire && last_wbeat) state_d = S_WAIT;
         S_WAIT:  if (wait_done) state_d = we_q ? S_ACK : S_RDATA;
         S_RDATA: if (resp_ready && resp_last) state_d = S_IDLE;
         S_ACK:   if (resp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q    <= 1'b0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         addr_q    <= '0;
         beat_q    <= '0;
         cnt_q     <= '0;
         resp_data <= '0;
         resp_last <= 1'b0;
         resp_err  <= 1'b0;
      end else begin
         live_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (req_fire) begin
                  we_q   <= req_we;
                  addr_q <= req_addr;
                  err_q  <= req_err;
                  beat_q <= '0;
                  cnt_q  <= LAT_V;
               end
            end
            S_WDATA: begin
               if (w_fire) begin
                  beat_q <= beat_q + 1'b1;
                  cnt_q  <= LAT_V;
               end
            end
            S_WAIT: begin
               cnt_q <= cnt_q - 1'b1;
               if (wait_done) begin
                  // Store ack and error beat are single final beats carrying no data.
                  beat_q    <= '0;
                  resp_data <= '0;
                  resp_last <= 1'b1;
                  resp_err  <= err_q;
                  if (!we_q && !err_q) begin
                     resp_data <= mem[addr_q];
                     resp_last <= (BEATS == 1);
                  end
               end
            end
            S_RDATA, S_ACK: begin
               if (resp_ready) begin
                  if (resp_last) begin
                     resp_data <= '0;
                     resp_last <= 1'b0;
                     resp_err  <= 1'b0;
                  end else begin
                     beat_q    <= beat_q + 1'b1;
                     resp_data <= mem[rd_next];
                     resp_last <= (beat_q == BEAT_W'(BEATS - 2));
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Storage is never reset; out-of-range stores consume beats without writing.
   always_ff @(posedge clk) begin
      if (w_fire && !err_q) mem[wr_row] <= w_data;
   end

endmodule

// File: tb/tb_vec_mem_responder.sv
// Randomized bench for vec_mem_responder: a row-array reference model predicts load
// data, range errors, latency and beat framing for each scenario task.
module tb_vec_mem_responder;
   localparam int BANKS  = 8;
   localparam int DEPTH  = 120;
   localparam int VLEN   = 32;
   localparam int DW     = 32;
   localparam int ADDR_W = 7;
   localparam int LAT    = 2;
   localparam int BEATS  = VLEN / BANKS;
   localparam int RW     = BANKS * DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_we = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic              w_valid = 1'b0;
   logic              w_ready;
   logic [RW-1:0]     w_data = '0;
   logic              resp_valid;
   logic              resp_ready = 1'b0;
   logic [RW-1:0]     resp_data;
   logic              resp_last;
   logic              resp_err;
   logic [2:0]        dbg_state;

   vec_mem_responder #(
      .BANKS(BANKS), .DEPTH(DEPTH), .VLEN(VLEN), .DW(DW), .ADDR_W(ADDR_W), .LAT(LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_last(resp_last), .resp_err(resp_err), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int busy_rdy = 0;

   // Reference model: plain array of rows.
   logic [RW-1:0] ref_mem [DEPTH];

   logic [RW-1:0] got_d [$];
   logic          got_l [$];
   logic          got_e [$];

   function automatic bit exp_err(input int addr);
      return (addr + BEATS - 1) > (DEPTH - 1);
   endfunction

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int k = 0; k < BANKS; k++) r[k*DW +: DW] = $urandom;
      return r;
   endfunction

   task automatic model_store(input int addr, input logic [RW-1:0] b [BEATS]);
      if (!exp_err(addr))
         for (int i = 0; i < BEATS; i++) ref_mem[addr + i] = b[i];
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_req(input logic we, input logic [ADDR_W-1:0] addr, output int ok);
      logic rdy;
      ok = 0;
      req_we = we;
      req_addr = addr;
      req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         rdy = req_ready;
         @(posedge clk); #1;
         if (rdy) begin
            ok = 1;
            break;
         end
      end
      req_valid = 1'b0;
   endtask

   // Entered one sample point after the edge that starts the wait (cycle 1).
   task automatic collect(input int mode, output int lat, output int stall_bad,
                          output int timeout, output logic valid_after);
      int cyc, k;
      bit stalled, rr;
      logic [RW-1:0] hd;
      logic hl, he;
      got_d.delete(); got_l.delete(); got_e.delete();
      cyc = 1; k = 0; stalled = 0; lat = -1; stall_bad = 0; timeout = 0;
      valid_after = 1'bx; hd = '0; hl = 1'b0; he = 1'b0;
      forever begin
         if (cyc > 200) begin
            timeout = 1;
            break;
         end
         if (req_ready) busy_rdy++;
         if (resp_valid) begin
            if (lat < 0) lat = cyc;
            if (stalled && (resp_data !== hd || resp_last !== hl || resp_err !== he))
               stall_bad++;
            rr = (mode == 0) ? 1'b1 : (k % 3 == 0);
            k++;
            resp_ready = rr;
            hd = resp_data; hl = resp_last; he = resp_err;
            stalled = !rr;
            if (rr) begin
               got_d.push_back(resp_data);
               got_l.push_back(resp_last);
               got_e.push_back(resp_err);
            end
            @(posedge clk); #1; cyc++;
            if (rr && hl) begin
               valid_after = resp_valid;
               break;
            end
         end else begin
            @(posedge clk); #1; cyc++;
         end
      end
      resp_ready = 1'b0;
   endtask

   task automatic do_store(input logic [ADDR_W-1:0] addr, input logic [RW-1:0] beats [BEATS],
                           input logic [7:0] pat, input int plen,
                           output int lat, output int timeout);
      int ok, n, i, sb;
      logic va;
      bit v, wr;
      timeout = 0; lat = -1;
      send_req(1'b1, addr, ok);
      if (ok == 0) begin
         timeout = 1;
         return;
      end
      n = 0; i = 0;
      while (n < BEATS) begin
         if (i > 200) begin
            timeout = 1;
            break;
         end
         v = pat[i % plen];
         i++;
         w_valid = v;
         w_data = v ? beats[n] : rand_row();
         wr = w_ready;
         if (req_ready) busy_rdy++;
         @(posedge clk); #1;
         if (v && wr) n++;
      end
      w_valid = 1'b0;
      if (timeout != 0) return;
      collect(0, lat, sb, timeout, va);
   endtask

   task automatic do_load(input logic [ADDR_W-1:0] addr, input int mode, output int lat,
                          output int stall_bad, output int timeout, output logic va);
      int ok;
      lat = -1; stall_bad = 0; va = 1'bx;
      send_req(1'b0, addr, ok);
      if (ok == 0) begin
         timeout = 1;
         return;
      end
      collect(mode, lat, stall_bad, timeout, va);
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (req_ready !== 1'b0 || w_ready !== 1'b0 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: req_ready=%b w_ready=%b resp_valid=%b, required 0 0 0",
                  req_ready, w_ready, resp_valid);
      end
      n_checks++;
      if (resp_data !== '0 || resp_last !== 1'b0 || resp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_resp: data=%h last=%b err=%b, required 0 0 0",
                  resp_data, resp_last, resp_err);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_no_edge: req_ready=%b required 0", req_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_first_edge: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_store_load();
      logic [RW-1:0] b [BEATS];
      int lat, to, sb, addr;
      logic va;
      for (int it = 0; it < 4; it++) begin
         if (it == 0) begin
            addr = 0;
            for (int bt = 0; bt < BEATS; bt++)
               for (int k = 0; k < BANKS; k++) b[bt][k*DW +: DW] = 32'(100 * bt + k);
         end else begin
            addr = $urandom_range(4, 100);
            for (int bt = 0; bt < BEATS; bt++) b[bt] = rand_row();
         end
         do_store(ADDR_W'(addr), b, 8'h01, 1, lat, to);
         model_store(addr, b);
         n_checks++;
         if (to != 0 || lat != LAT + 1) begin
            n_fail++;
            $display("FAIL store_ack_latency: addr=%0d timeout=%0d latency=%0d, required 0 and %0d",
                     addr, to, lat, LAT + 1);
         end
         n_checks++;
         if (got_d.size() != 1 || got_l[0] !== 1'b1 || got_e[0] !== 1'b0 || got_d[0] !== '0) begin
            n_fail++;
            $display("FAIL store_ack_beat: beats=%0d last=%b err=%b data=%h, required 1 1 0 0",
                     got_d.size(), got_l[0], got_e[0], got_d[0]);
         end
         do_load(ADDR_W'(addr), 0, lat, sb, to, va);
         n_checks++;
         if (to != 0 || lat != LAT + 1 || got_d.size() != BEATS || va !== 1'b0) begin
            n_fail++;
            $display("FAIL load_frame: addr=%0d timeout=%0d latency=%0d beats=%0d valid_after=%b, required 0 %0d %0d 0",
                     addr, to, lat, got_d.size(), va, LAT + 1, BEATS);
         end
         for (int i = 0; i < got_d.size(); i++) begin
            n_checks++;
            if (got_d[i] !== ref_mem[addr + i] || got_l[i] !== (i == BEATS - 1) || got_e[i] !== 1'b0) begin
               n_fail++;
               $display("FAIL load_beat%0d: row=%0d data=%h last=%b err=%b, required data=%h last=%b err=0",
                        i, addr + i, got_d[i], got_l[i], got_e[i], ref_mem[addr + i], (i == BEATS - 1));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [RW-1:0] b [BEATS];
      int lat, to, sb;
      logic va;
      for (int bt = 0; bt < BEATS; bt++) b[bt] = rand_row();
      do_store(ADDR_W'(40), b, 8'h01, 1, lat, to);
      model_store(40, b);
      do_load(ADDR_W'(40), 1, lat, sb, to, va);
      n_checks++;
      if (to != 0 || sb != 0 || got_d.size() != BEATS) begin
         n_fail++;
         $display("FAIL stall_hold: timeout=%0d unstable_cycles=%0d beats=%0d, required 0 0 %0d",
                  to, sb, got_d.size(), BEATS);
      end
      for (int i = 0; i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== ref_mem[40 + i] || got_l[i] !== (i == BEATS - 1)) begin
            n_fail++;
            $display("FAIL stall_beat%0d: data=%h last=%b, required data=%h last=%b",
                     i, got_d[i], got_l[i], ref_mem[40 + i], (i == BEATS - 1));
         end
      end
   endtask

   task automatic test_errors();
      logic [RW-1:0] b [BEATS];
      int lat, to, sb;
      logic va;
      for (int bt = 0; bt < BEATS; bt++) b[bt] = rand_row();
      do_store(ADDR_W'(116), b, 8'h01, 1, lat, to);
      model_store(116, b);
      do_load(ADDR_W'(117), 0, lat, sb, to, va);
      n_checks++;
      if (to != 0 || got_d.size() != 1 || got_e[0] !== exp_err(117) || got_l[0] !== 1'b1 ||
          got_d[0] !== '0 || va !== 1'b0) begin
         n_fail++;
         $display("FAIL err_load: timeout=%0d beats=%0d err=%b last=%b data=%h valid_after=%b, required 0 1 1 1 0 0",
                  to, got_d.size(), got_e[0], got_l[0], got_d[0], va);
      end
      for (int bt = 0; bt < BEATS; bt++) b[bt] = rand_row();
      do_store(ADDR_W'(118), b, 8'h01, 1, lat, to);
      model_store(118, b);
      n_checks++;
      if (to != 0 || got_d.size() != 1 || got_e[0] !== exp_err(118) || got_l[0] !== 1'b1 ||
          got_d[0] !== '0) begin
         n_fail++;
         $display("FAIL err_store_ack: timeout=%0d beats=%0d err=%b last=%b data=%h, required 0 1 1 1 0",
                  to, got_d.size(), got_e[0], got_l[0], got_d[0]);
      end
      do_load(ADDR_W'(116), 0, lat, sb, to, va);
      n_checks++;
      if (to != 0 || got_d.size() != BEATS) begin
         n_fail++;
         $display("FAIL err_readback_frame: timeout=%0d beats=%0d, required 0 %0d", to, got_d.size(), BEATS);
      end
      for (int i = 0; i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== ref_mem[116 + i] || got_e[i] !== 1'b0) begin
            n_fail++;
            $display("FAIL err_readback_row%0d: data=%h err=%b, required data=%h err=0",
                     116 + i, got_d[i], got_e[i], ref_mem[116 + i]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [RW-1:0] b [BEATS];
      int lat, to, sb;
      logic va;
      for (int bt = 0; bt < BEATS; bt++) b[bt] = rand_row();
      busy_rdy = 0;
      do_store(ADDR_W'(60), b, 8'b0010_1101, 6, lat, to);
      model_store(60, b);
      n_checks++;
      if (to != 0 || lat != LAT + 1 || busy_rdy != 0) begin
         n_fail++;
         $display("FAIL gaps_ack: timeout=%0d latency=%0d busy_ready_cycles=%0d, required 0 %0d 0",
                  to, lat, busy_rdy, LAT + 1);
      end
      do_load(ADDR_W'(60), 0, lat, sb, to, va);
      for (int i = 0; i < BEATS; i++) begin
         n_checks++;
         if (i >= got_d.size() || got_d[i] !== ref_mem[60 + i]) begin
            n_fail++;
            $display("FAIL gaps_row%0d: beats=%0d data=%h, required data=%h",
                     60 + i, got_d.size(), (i < got_d.size()) ? got_d[i] : '0, ref_mem[60 + i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ok, lat, to, sb;
      logic va;
      send_req(1'b0, ADDR_W'(40), ok);
      req_valid = 1'b1;
      req_we = 1'b0;
      req_addr = '0;
      busy_rdy = 0;
      collect(0, lat, sb, to, va);
      n_checks++;
      if (ok == 0 || to != 0 || busy_rdy != 0 || got_d.size() != BEATS || got_d[0] !== ref_mem[40]) begin
         n_fail++;
         $display("FAIL busy_first: accepted=%0d timeout=%0d busy_ready_cycles=%0d beats=%0d, required 1 0 0 %0d",
                  ok, to, busy_rdy, got_d.size(), BEATS);
      end
      n_checks++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_idle_ready: req_ready=%b required 1", req_ready);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      collect(0, lat, sb, to, va);
      n_checks++;
      if (to != 0 || lat != LAT + 1 || got_d.size() != BEATS) begin
         n_fail++;
         $display("FAIL busy_second: timeout=%0d latency=%0d beats=%0d, required 0 %0d %0d",
                  to, lat, got_d.size(), LAT + 1, BEATS);
      end
      for (int i = 0; i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== ref_mem[i]) begin
            n_fail++;
            $display("FAIL busy_second_row%0d: data=%h required %h", i, got_d[i], ref_mem[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int ok, lat, to, sb, w;
      logic va;
      send_req(1'b0, ADDR_W'(0), ok);
      w = 0;
      while (resp_valid !== 1'b1 && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      resp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      resp_ready = 1'b0;
      n_checks++;
      if (ok == 0 || resp_valid !== 1'b1 || resp_data !== ref_mem[2]) begin
         n_fail++;
         $display("FAIL midreset_beat2: accepted=%0d valid=%b data=%h, required 1 1 %h",
                  ok, resp_valid, resp_data, ref_mem[2]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (resp_valid !== 1'b0 || resp_data !== '0 || resp_last !== 1'b0 || resp_err !== 1'b0 ||
          req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_outputs: valid=%b data=%h last=%b err=%b req_ready=%b, required all 0",
                  resp_valid, resp_data, resp_last, resp_err, req_ready);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_release: req_ready=%b required 0", req_ready);
      end
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_first_edge: req_ready=%b resp_valid=%b, required 1 0", req_ready, resp_valid);
      end
      do_load(ADDR_W'(0), 0, lat, sb, to, va);
      n_checks++;
      if (to != 0 || got_d.size() != BEATS) begin
         n_fail++;
         $display("FAIL midreset_reload: timeout=%0d beats=%0d, required 0 %0d", to, got_d.size(), BEATS);
      end
      for (int i = 0; i < got_d.size(); i++) begin
         n_checks++;
         if (got_d[i] !== ref_mem[i]) begin
            n_fail++;
            $display("FAIL midreset_row%0d: data=%h required %h", i, got_d[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_stall();
      test_errors();
      test_gaps();
      test_back_to_back();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/vec_mem_responder.md
Name: vec_mem_responder

Overview:
- Banked vector data memory that services vector load/store requests issued by the LSQ/vector execution side.
- Holds DEPTH rows of BANKS 32-bit words; one row is one beat, and one vector transfer is VLEN/BANKS consecutive rows.
- Is the memory-side endpoint of the vector load/store interface: it accepts a request, consumes store beats or produces load beats, then acknowledges.
- Replaces the behavioural data memory array with synthesizable sequential RTL.

Parameters:
- BANKS, 8, words per row (lanes per beat).
- DEPTH, 120, number of rows.
- VLEN, 32, elements per vector; BEATS = VLEN/BANKS = 4.
- DW, 32, element width in bits.
- ADDR_W, 7, row address width, equal to clog2(DEPTH).
- LAT, 2, access latency in cycles; legal range 1..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  starting row of the vector.
- w_valid  in  1  store beat present.
- w_ready  out  1  block accepts a store beat.
- w_data  in  BANKS*DW  store beat; lane k occupies bits [k*DW +: DW].
- resp_valid  out  1  response beat present.
- resp_ready  in  1  consumer accepts the response beat.
- resp_data  out  BANKS*DW  load beat, same lane packing as w_data; 0 for store acks and errors.
- resp_last  out  1  final response beat of the transaction.
- resp_err  out  1  address out of range.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, beat and latency counters=0.
  - req_ready=0 while rst_n is low, 1 from the first edge after release.
  - w_ready=0, resp_valid=0, resp_data=0, resp_last=0, resp_err=0.
  - Memory contents are not cleared.
- Range check at accept: err = (req_addr + BEATS - 1 > DEPTH - 1). Compute at ADDR_W+2 bits so the sum cannot wrap.
- States: IDLE, WDATA, WAIT, RDATA, ACK.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready, latch we, addr and err; clear beat=0; drop req_ready the next cycle.
  - Store goes to WDATA; load goes to WAIT with the latency counter loaded with LAT.
- WDATA:
  - w_ready=1.
  - Each w_valid & w_ready handshake writes row addr+beat with all BANKS lanes, unless err, in which case the beat is consumed and discarded.
  - beat increments per handshake; gaps in w_valid are tolerated.
  - After the handshake on beat BEATS-1, go to WAIT with the counter loaded with LAT; w_ready drops the next cycle.
- WAIT:
  - Counter decrements each cycle; at 1, move on.
  - Load goes to RDATA; store goes to ACK.
  - Total: the first load beat appears exactly LAT+1 cycles after the request handshake; a store ack appears LAT+1 cycles after the last write handshake.
- RDATA:
  - resp_valid=1, resp_data=row addr+beat, resp_last=(beat==BEATS-1), resp_err=0.
  - Beat advances only on resp_ready. While stalled, resp_data, resp_last and resp_err hold stable.
  - After the last beat is accepted, return to IDLE.
  - If err: a single beat only, with resp_data=0, resp_last=1, resp_err=1; then IDLE.
- ACK:
  - One beat: resp_valid=1, resp_last=1, resp_err=err, resp_data=0.
  - Hold until resp_ready, then return to IDLE.
- Memory access timing:
  - Reads are registered: row data is captured into the output register when entering RDATA and on each accepted beat.
  - A load issued immediately after a store ack sees the stored data (no read-before-write hazard, since transactions never overlap).
- Busy handling: req_valid outside IDLE is ignored; req_ready=0.
- The w_* port is ignored outside WDATA.
- Reset mid-transaction: immediate return to IDLE with outputs at reset values. Rows already written keep their data; no ack is issued.
- resp_valid deasserts in the cycle after the final accepted beat, even if resp_ready stays high.

Test Plan:
- Store addr=0, beats lane k of beat b = 100*b+k; then load addr=0, resp_ready=1 -> 4 beats with identical data, resp_last only on beat 3, first beat 3 cycles after the load handshake (LAT=2), resp_err=0 throughout.
- Load addr=40 with resp_ready toggling 1,0,0,1,... -> resp_data/resp_last stable while stalled; exactly 4 beats accepted, in row order 40..43.
- Load addr=117 -> one beat with resp_err=1, resp_last=1, resp_data=0. Store addr=118 -> all 4 w beats consumed, ack with resp_err=1, and rows 116..119 unchanged on readback.
- Store with w_valid gaps (1,0,1,1,0,1) -> 4 rows written correctly; ack 3 cycles after the 4th write handshake; req_ready=0 until the ack is accepted.
- Second req_valid asserted during an active load -> not accepted (req_ready=0); accepted the cycle after return to IDLE.
- rst_n pulsed low during load beat 2 -> resp_valid drops immediately and the block is back in IDLE. After rst_n rises, req_ready=1 from the first edge and previously stored data reads back intact.
